// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: bus widths, FSM state type and defaults.
`ifndef ADDR_BUS
`define ADDR_BUS 32
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif

package mem_arbiter_pkg;
    localparam int ADDR_W        = `ADDR_BUS;
    localparam int DATA_W        = `DATA_BUS;
    localparam int WIDTH_W       = 4;
    localparam int NUM_PROCS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // Round-robin successor of a requester index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PROCS = NUM_PROCS_DEF,
    parameter int IDX_W     = $clog2(NUM_PROCS)
) (
    input  logic [NUM_PROCS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PROCS-1:0] grant,
    output logic [IDX_W-1:0]     idx
);
    int   cand;
    logic found;

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        cand  = 0;
        for (int i = 0; i < NUM_PROCS; i++) begin
            cand = (int'(ptr) + i) % NUM_PROCS;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_PROCS requesters; all outputs registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PROCS = NUM_PROCS_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PROCS-1:0]               req_ce_i,
    input  logic [NUM_PROCS-1:0]               req_we_i,
    input  logic [NUM_PROCS-1:0][ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_PROCS-1:0][WIDTH_W-1:0]  req_width_i,
    input  logic [NUM_PROCS-1:0][DATA_W-1:0]   req_data_i,
    output logic [DATA_W-1:0]                  req_data_o,
    output logic [NUM_PROCS-1:0]               req_ready_o,
    output logic                               mem_ce_o,
    output logic                               mem_we_o,
    output logic [ADDR_W-1:0]                  mem_addr_o,
    output logic [WIDTH_W-1:0]                 mem_width_o,
    output logic [DATA_W-1:0]                  mem_data_o,
    input  logic [DATA_W-1:0]                  mem_data_i,
    input  logic                               mem_ready_i,
    output logic [NUM_PROCS-1:0]               grant_o,
    output logic                               busy_o
);
    localparam int IDX_W = $clog2(NUM_PROCS);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d, winner_q, winner_d;
    logic [NUM_PROCS-1:0] pick_grant;
    logic [IDX_W-1:0]     pick_idx;

    logic                 mem_ce_d, mem_we_d, busy_d;
    logic [ADDR_W-1:0]    mem_addr_d;
    logic [WIDTH_W-1:0]   mem_width_d;
    logic [DATA_W-1:0]    mem_data_d, req_data_d;
    logic [NUM_PROCS-1:0] req_ready_d, grant_d;

    rr_pick #(.NUM_PROCS(NUM_PROCS), .IDX_W(IDX_W)) u_pick (
        .req   (req_ce_i),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        mem_ce_d    = mem_ce_o;
        mem_we_d    = mem_we_o;
        mem_addr_d  = mem_addr_o;
        mem_width_d = mem_width_o;
        mem_data_d  = mem_data_o;
        req_data_d  = req_data_o;
        req_ready_d = '0;
        grant_d     = grant_o;
        busy_d      = busy_o;

        unique case (state_q)
            ST_IDLE: begin
                if (|req_ce_i) begin
                    state_d     = ST_ISSUE;
                    winner_d    = pick_idx;
                    grant_d     = pick_grant;
                    busy_d      = 1'b1;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = req_we_i[pick_idx];
                    mem_addr_d  = req_addr_i[pick_idx];
                    mem_width_d = req_width_i[pick_idx];
                    mem_data_d  = req_data_i[pick_idx];
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // Held here without limit; the winner's own req_ce_i no longer matters.
                if (mem_ready_i) begin
                    state_d     = ST_DONE;
                    mem_ce_d    = 1'b0;
                    req_data_d  = mem_data_i;
                    req_ready_d = grant_o;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = IDX_W'(rr_next(int'(winner_q), NUM_PROCS));
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            winner_q    <= '0;
            mem_ce_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_width_o <= '0;
            mem_data_o  <= '0;
            req_data_o  <= '0;
            req_ready_o <= '0;
            grant_o     <= '0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            mem_ce_o    <= mem_ce_d;
            mem_we_o    <= mem_we_d;
            mem_addr_o  <= mem_addr_d;
            mem_width_o <= mem_width_d;
            mem_data_o  <= mem_data_d;
            req_data_o  <= req_data_d;
            req_ready_o <= req_ready_d;
            grant_o     <= grant_d;
            busy_o      <= busy_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds against a round-robin model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [N-1:0]                req_ce, req_we;
    logic [N-1:0][ADDR_W-1:0]    req_addr;
    logic [N-1:0][WIDTH_W-1:0]   req_width;
    logic [N-1:0][DATA_W-1:0]    req_data;
    logic [DATA_W-1:0]           req_data_o;
    logic [N-1:0]                req_ready_o;
    logic                        mem_ce_o, mem_we_o;
    logic [ADDR_W-1:0]           mem_addr_o;
    logic [WIDTH_W-1:0]          mem_width_o;
    logic [DATA_W-1:0]           mem_data_o;
    logic [DATA_W-1:0]           mem_data_i;
    logic                        mem_ready_i;
    logic [N-1:0]                grant_o;
    logic                        busy_o;

    mem_arbiter #(.NUM_PROCS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_ce_i    (req_ce),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_width_i (req_width),
        .req_data_i  (req_data),
        .req_data_o  (req_data_o),
        .req_ready_o (req_ready_o),
        .mem_ce_o    (mem_ce_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_width_o (mem_width_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ready_i (mem_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int model_ptr = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first pending requester scanning upward from the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] ce, input int p);
        for (int k = 0; k < N; k++)
            if (ce[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic randomize_fields(input int i);
        req_we[i]    = 1'($urandom_range(0, 1));
        req_addr[i]  = ADDR_W'($urandom);
        req_width[i] = WIDTH_W'($urandom_range(0, 15));
        req_data[i]  = DATA_W'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ce"},    64'(mem_ce_o),    64'd0);
        check({tag, "_we"},    64'(mem_we_o),    64'd0);
        check({tag, "_addr"},  64'(mem_addr_o),  64'd0);
        check({tag, "_width"}, 64'(mem_width_o), 64'd0);
        check({tag, "_mdata"}, 64'(mem_data_o),  64'd0);
        check({tag, "_rdata"}, 64'(req_data_o),  64'd0);
        check({tag, "_ready"}, 64'(req_ready_o), 64'd0);
        check({tag, "_grant"}, 64'(grant_o),     64'd0);
        check({tag, "_busy"},  64'(busy_o),      64'd0);
    endtask

    // Serve one transaction starting in IDLE with requests already driven.
    // exp_w >= 0 forces the expected winner; otherwise the model decides.
    task automatic serve(input int exp_w, input int lat, input bit drop_mid, input logic [DATA_W-1:0] rdata);
        int                 w, ce_wait;
        logic               e_we;
        logic [ADDR_W-1:0]  e_addr;
        logic [WIDTH_W-1:0] e_width;
        logic [DATA_W-1:0]  e_data;
        w = (exp_w >= 0) ? exp_w : model_pick(req_ce, model_ptr);
        if (w < 0) return;
        e_we = req_we[w]; e_addr = req_addr[w]; e_width = req_width[w]; e_data = req_data[w];

        ce_wait = 0;
        while (mem_ce_o !== 1'b1 && ce_wait < 20) begin
            tick();
            ce_wait++;
        end
        check("ce_rise", 64'(mem_ce_o), 64'd1);
        if (mem_ce_o !== 1'b1) begin
            req_ce = '0;
            return;
        end
        check("ce_latency", 64'(ce_wait), 64'd1);
        check("grant",  64'(grant_o),     64'd1 << w);
        check("busy",   64'(busy_o),      64'd1);
        check("we",     64'(mem_we_o),    64'(e_we));
        check("addr",   64'(mem_addr_o),  64'(e_addr));
        check("width",  64'(mem_width_o), 64'(e_width));
        check("wdata",  64'(mem_data_o),  64'(e_data));

        // ISSUE: a stray ready here must be ignored; winner's fields change but are already latched.
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_data_i  = DATA_W'($urandom);
        req_addr[w] = ADDR_W'($urandom);
        req_data[w] = DATA_W'($urandom);
        tick();
        mem_ready_i = 1'b0;
        if (drop_mid) req_ce[w] = 1'b0;
        for (int k = 0; k < lat; k++) begin
            tick();
            check("wait_ce",    64'(mem_ce_o),    64'd1);
            check("wait_addr",  64'(mem_addr_o),  64'(e_addr));
            check("wait_ready", 64'(req_ready_o), 64'd0);
        end

        mem_data_i  = rdata;
        mem_ready_i = 1'b1;
        tick();
        check("ready_pulse", 64'(req_ready_o), 64'd1 << w);
        check("done_ce",     64'(mem_ce_o),    64'd0);
        if (!e_we) check("rdata", 64'(req_data_o), 64'(rdata));
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_data_i  = DATA_W'($urandom);
        req_ce[w]   = 1'b0;
        tick();
        check("idle_ready", 64'(req_ready_o), 64'd0);
        check("idle_grant", 64'(grant_o),     64'd0);
        check("idle_busy",  64'(busy_o),      64'd0);
        mem_ready_i = 1'b0;
        model_ptr   = (w + 1) % N;
    endtask

    initial begin
        rst = 1'b0;
        req_ce = '0; req_we = '0; req_addr = '0; req_width = '0; req_data = '0;
        mem_data_i = '0; mem_ready_i = 1'b0;
        for (int i = 0; i < N; i++) randomize_fields(i);
        req_ce = '1;
        tick();
        tick();
        check_all_zero("reset");

        // Contention: all four requesting from reset release, order 0,1,2,3.
        rst = 1'b1;
        for (int i = 0; i < N; i++) serve(i, $urandom_range(0, 3), 1'b0, DATA_W'($urandom));
        check("contention_drained", 64'(req_ce), 64'd0);

        // Single read at 0x100 returning 0xDEADBEEF three cycles after mem_ce_o.
        req_ce = 4'b0001; req_we[0] = 1'b0; req_addr[0] = 32'h100; req_width[0] = 4'd4;
        serve(0, 2, 1'b0, 32'hDEADBEEF);
        check("single_rdata_hold", 64'(req_data_o), 64'hDEADBEEF);

        // Wrap: serving requester 2 leaves the pointer at 3, so 3 wins over 0.
        req_ce = 4'b0100; req_we[2] = 1'b0;
        serve(2, 1, 1'b0, DATA_W'($urandom));
        req_ce = 4'b1001;
        serve(3, 0, 1'b0, DATA_W'($urandom));
        serve(0, 1, 1'b0, DATA_W'($urandom));

        // Abort: requester 1 drops its request during WAIT; access still completes.
        req_ce = 4'b0010;
        serve(1, 3, 1'b1, DATA_W'($urandom));

        // Reset during WAIT abandons the access; a late ready is ignored.
        req_ce = 4'b0001;
        tick();
        tick();
        check("pre_reset_ce", 64'(mem_ce_o), 64'd1);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        req_ce = '0;
        tick();
        tick();
        rst = 1'b1;
        mem_ready_i = 1'b1;
        mem_data_i  = DATA_W'($urandom);
        tick();
        mem_ready_i = 1'b0;
        check_all_zero("late_ready");
        tick();
        check("late_ready_pulse", 64'(req_ready_o), 64'd0);
        model_ptr = 0;
        req_ce = 4'b0110;
        serve(1, 1, 1'b0, DATA_W'($urandom));
        serve(2, 0, 1'b0, DATA_W'($urandom));

        // Randomized rounds against the model.
        for (int r = 0; r < 24; r++) begin
            int guard;
            for (int i = 0; i < N; i++) randomize_fields(i);
            req_ce = N'($urandom_range(1, (1 << N) - 1));
            guard = 0;
            while (req_ce != '0 && guard < 3 * N) begin
                if (guard < N && $urandom_range(0, 3) == 0) begin
                    int j;
                    j = $urandom_range(0, N - 1);
                    randomize_fields(j);
                    req_ce[j] = 1'b1;
                end
                serve(-1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), DATA_W'($urandom));
                guard++;
            end
            req_ce = '0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
